pes_ic_cpu_if: RTL and testbench
================================

Name: pes_ic_cpu_if

Overview:
- Processor-side handshake sequencer downstream of pes_ic. It consumes intr_out and the controller-driven vector, and produces the active-low intr_in pulses and the processor-driven bus words (mode/priority programming, EOI).
- Presents a clean vec_valid/eoi_req interface to the CPU core.
- Bus tristate is resolved at top level from bus_drive and ctrl_oe.

Parameters:
ACK_DLY, 6, cycles between seeing intr_out and the first ack pulse (1..255)
GAP, 10, idle cycles after EOI before re-arming (0..255)
TMO_CYC, 32, vector-capture timeout in cycles (used only with the optional feature)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset; synchronous, active-high
intr_out  input  1  interrupt request from pes_ic
ctrl_oe  input  1  pes_ic bus_oe; high = controller drives bus
bus_in  input  8  resolved bus value
bus_out  output  8  value this block drives
bus_drive  output  1  high = this block drives the bus
intr_in  output  1  ack/EOI strobe to pes_ic, active-low, 1-cycle pulses
cfg_start  input  1  1-cycle request to program the controller
cfg_prio  input  1  0 = polling mode, 1 = priority mode
prio_order  input  24  [3*r+:3] = source id at rank r (r=0 highest)
vec_valid  output  1  captured vector available to core
vec_id  output  3  serviced source id
eoi_req  input  1  core finished ISR (1-cycle)
busy  output  1  high when not in IDLE
vec_err  output  1  sticky: vector prefix mismatch

Behaviour:
- Reset values: bus_out=0, bus_drive=0, intr_in=1, vec_valid=0, vec_id=0, busy=0, vec_err=0, mode_q=0. Reset mid-operation aborts immediately to IDLE.
- mode_q latches cfg_prio on an accepted cfg_start. Prefixes depend on mode_q:
  - Vector prefix: polling 5'b01011, priority 5'b10011.
  - EOI prefix: polling 5'b10100, priority 5'b01100.
- FSM states: IDLE, CFG, ACK_WAIT, ACK1, CAPTURE, ACK2, SERVICE, EOI, HOLDOFF.
- IDLE:
  - cfg_start takes priority over intr_out in the same cycle and goes to CFG.
  - Otherwise intr_out=1 goes to ACK_WAIT, counter cleared.
  - cfg_start outside IDLE is ignored.
- CFG: bus_drive=1, one word per cycle.
  - Polling: single word 8'h01, 1 cycle.
  - Priority: 4 words; word k = {prio_order[6k+:3], prio_order[6k+3+:3], 2'b10}, k=0..3.
  - After the last word: bus_drive=0, bus_out=0, go to IDLE.
- ACK_WAIT: counts ACK_DLY cycles.
  - intr_out falling before expiry: go back to IDLE (spurious, no pulse).
  - On expiry: go to ACK1.
- ACK1: intr_in=0 for exactly 1 cycle, then CAPTURE.
- CAPTURE: wait for ctrl_oe=1; on that cycle sample bus_in.
  - vec_id <= bus_in[2:0].
  - If bus_in[7:3] != vector prefix, set vec_err (sticky until reset or next accepted cfg_start) and suppress SERVICE.
  - Go to ACK2.
- ACK2: intr_in=0 for 1 cycle.
  - Good vector: go to SERVICE.
  - Bad vector: go directly to EOI, so the controller is never left stuck.
- SERVICE: vec_valid=1.
  - eoi_req is accepted in any cycle vec_valid=1, including the first.
  - eoi_req outside SERVICE is ignored.
  - On accept: vec_valid=0 next cycle, go to EOI.
- EOI: for 1 cycle, bus_drive=1, bus_out={EOI prefix, vec_id}, intr_in=0. Next cycle bus_drive=0, bus_out=0, then HOLDOFF.
- HOLDOFF: GAP cycles (GAP=0 means 0 extra cycles), then IDLE. intr_out is ignored here.
- bus_drive is never 1 while ctrl_oe=1.
  - If ctrl_oe rises during CFG or EOI, bus_drive drops that cycle.
  - The word is not retried.
- busy = (state != IDLE), registered.
- Latency: intr_out high at cycle t gives intr_in low at cycle t+ACK_DLY+1.

Optional Feature:
- Macro: PES_IC_CPU_IF_TIMEOUT_EN.
- Defined:
  - CAPTURE counts cycles. If ctrl_oe is not seen within TMO_CYC cycles, set output tmo_err (sticky, reset-cleared) and return to IDLE with no further pulses.
  - tmo_err port exists only when the macro is defined.
- Undefined: CAPTURE waits indefinitely, and no counter or port is present.

Decomposition:
- Package pes_ic_pkg:
  - State enum encoding.
  - Prefix constants VEC_PFX_POLL/VEC_PFX_PRIO/EOI_PFX_POLL/EOI_PFX_PRIO.
  - CFG_POLL_WORD=8'h01 and CFG_PRIO_TAG=2'b10, shared with pes_ic.
- One sub-module, pes_ic_cpu_if_cnt: loadable 8-bit down-counter with zero flag, reused for ACK_DLY, GAP and timeout.

Test Plan:
1. Reset, then cfg_start with cfg_prio=0 -> bus_out=8'h01 with bus_drive=1 for 1 cycle; intr_in stays 1.
2. cfg_prio=1, prio_order for ranks 5,3,7,0,4,2,6,1 -> words 8'b101_011_10, 111_000_10, 100_010_10, 110_001_10 on consecutive cycles.
3. Polling: intr_out=1, controller drives 8'b01011_011 after ack1 -> intr_in low at ACK_DLY+1, vec_valid=1, vec_id=3; then eoi_req -> EOI word 8'b10100_011 with intr_in=0 for 1 cycle; busy drops after GAP.
4. Priority mode, controller drives 8'b01011_101 (wrong prefix) -> vec_err=1, vec_valid never asserted, EOI 8'b01100_101 still sent.
5. intr_out pulses for 3 cycles with ACK_DLY=6 -> no intr_in pulse, return to IDLE. Also: cfg_start and intr_out in the same cycle -> CFG first.
6. With PES_IC_CPU_IF_TIMEOUT_EN, ctrl_oe held 0 after ack1 -> tmo_err=1 after TMO_CYC=32 cycles, FSM in IDLE. Also: rst_in asserted during SERVICE -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pes_ic_pkg.sv
// Shared encodings for the pes_ic controller and its processor-side sequencer:
// FSM states, vector/EOI prefixes and configuration word helpers.
package pes_ic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_ACK_WAIT,
    ST_ACK1,
    ST_CAPTURE,
    ST_ACK2,
    ST_SERVICE,
    ST_EOI,
    ST_HOLDOFF
  } state_e;

  localparam logic [4:0] VEC_PFX_POLL = 5'b01011;
  localparam logic [4:0] VEC_PFX_PRIO = 5'b10011;
  localparam logic [4:0] EOI_PFX_POLL = 5'b10100;
  localparam logic [4:0] EOI_PFX_PRIO = 5'b01100;

  localparam logic [7:0] CFG_POLL_WORD = 8'h01;
  localparam logic [1:0] CFG_PRIO_TAG  = 2'b10;

  function automatic logic [4:0] vec_pfx(input logic prio);
    return prio ? VEC_PFX_PRIO : VEC_PFX_POLL;
  endfunction

  function automatic logic [4:0] eoi_pfx(input logic prio);
    return prio ? EOI_PFX_PRIO : EOI_PFX_POLL;
  endfunction

  // Word k carries the ids of ranks 2k and 2k+1, highest rank in the top bits.
  function automatic logic [7:0] cfg_prio_word(input logic [23:0] order, input logic [1:0] k);
    logic [23:0] sh;
    sh = order >> (5'(k) * 5'd6);
    return {sh[2:0], sh[5:3], CFG_PRIO_TAG};
  endfunction

endpackage

// File: rtl/pes_ic_cpu_if_cnt.sv
// Loadable 8-bit down-counter that stops at zero; shared by the ack delay,
// post-EOI holdoff and vector-capture timeout.
module pes_ic_cpu_if_cnt (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/pes_ic_cpu_if.sv
// Processor-side handshake sequencer for pes_ic: programming words, ack/EOI pulses
// and vector capture. Define PES_IC_CPU_IF_TIMEOUT_EN to add the capture timeout and tmo_err.
module pes_ic_cpu_if
  import pes_ic_pkg::*;
#(
  parameter int ACK_DLY = 6,
  parameter int GAP     = 10,
  parameter int TMO_CYC = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        intr_out,
  input  logic        ctrl_oe,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_drive,
  output logic        intr_in,
  input  logic        cfg_start,
  input  logic        cfg_prio,
  input  logic [23:0] prio_order,
  output logic        vec_valid,
  output logic [2:0]  vec_id,
  input  logic        eoi_req,
  output logic        busy,
  output logic        vec_err
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
  ,
  output logic        tmo_err
`endif
);

  localparam logic [7:0] ACK_LD = 8'(ACK_DLY - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP - 1);
  localparam logic [7:0] TMO_LD = 8'(TMO_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic        drive_q, drive_d;
  logic        intr_in_q, intr_in_d;
  logic        vec_valid_q, vec_valid_d;
  logic [2:0]  vec_id_q, vec_id_d;
  logic        busy_q, busy_d;
  logic        vec_err_q, vec_err_d;
  logic        mode_q, mode_d;
  logic        bad_q, bad_d;
  logic [1:0]  widx_q, widx_d;
  logic        cnt_load;
  logic [7:0]  cnt_val;
  logic        cnt_zero;
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
  logic        tmo_err_q, tmo_err_d;
`endif

  pes_ic_cpu_if_cnt u_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    bus_out_d   = bus_out_q;
    drive_d     = drive_q;
    intr_in_d   = 1'b1;
    vec_valid_d = vec_valid_q;
    vec_id_d    = vec_id_q;
    vec_err_d   = vec_err_q;
    mode_d      = mode_q;
    bad_d       = bad_q;
    widx_d      = widx_q;
    cnt_load    = 1'b0;
    cnt_val     = ACK_LD;
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
    tmo_err_d   = tmo_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          mode_d    = cfg_prio;
          vec_err_d = 1'b0;
          widx_d    = 2'd0;
          drive_d   = 1'b1;
          bus_out_d = cfg_prio ? cfg_prio_word(prio_order, 2'd0) : CFG_POLL_WORD;
          state_d   = ST_CFG;
        end else if (intr_out) begin
          cnt_load = 1'b1;
          cnt_val  = ACK_LD;
          state_d  = ST_ACK_WAIT;
        end
      end
      ST_CFG: begin
        if (!mode_q || widx_q == 2'd3) begin
          drive_d   = 1'b0;
          bus_out_d = '0;
          state_d   = ST_IDLE;
        end else begin
          widx_d    = widx_q + 2'd1;
          bus_out_d = cfg_prio_word(prio_order, widx_d);
        end
      end
      ST_ACK_WAIT: begin
        if (!intr_out) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          intr_in_d = 1'b0;
          state_d   = ST_ACK1;
        end
      end
      ST_ACK1: begin
        cnt_load = 1'b1;
        cnt_val  = TMO_LD;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (ctrl_oe) begin
          vec_id_d  = bus_in[2:0];
          bad_d     = (bus_in[7:3] != vec_pfx(mode_q));
          vec_err_d = vec_err_q | bad_d;
          intr_in_d = 1'b0;
          state_d   = ST_ACK2;
        end
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
        else if (cnt_zero) begin
          tmo_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
`endif
      end
      ST_ACK2: begin
        // A bad vector still gets an EOI so the controller releases its in-service bit.
        if (bad_q) begin
          drive_d   = 1'b1;
          bus_out_d = {eoi_pfx(mode_q), vec_id_q};
          intr_in_d = 1'b0;
          state_d   = ST_EOI;
        end else begin
          vec_valid_d = 1'b1;
          state_d     = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi_req) begin
          vec_valid_d = 1'b0;
          drive_d     = 1'b1;
          bus_out_d   = {eoi_pfx(mode_q), vec_id_q};
          intr_in_d   = 1'b0;
          state_d     = ST_EOI;
        end
      end
      ST_EOI: begin
        drive_d   = 1'b0;
        bus_out_d = '0;
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
          state_d  = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      bus_out_q   <= '0;
      drive_q     <= 1'b0;
      intr_in_q   <= 1'b1;
      vec_valid_q <= 1'b0;
      vec_id_q    <= '0;
      busy_q      <= 1'b0;
      vec_err_q   <= 1'b0;
      mode_q      <= 1'b0;
      bad_q       <= 1'b0;
      widx_q      <= '0;
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_out_q   <= bus_out_d;
      drive_q     <= drive_d;
      intr_in_q   <= intr_in_d;
      vec_valid_q <= vec_valid_d;
      vec_id_q    <= vec_id_d;
      busy_q      <= busy_d;
      vec_err_q   <= vec_err_d;
      mode_q      <= mode_d;
      bad_q       <= bad_d;
      widx_q      <= widx_d;
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  // Yield the bus immediately when the controller turns its drivers on; the word is lost.
  assign bus_drive = drive_q & ~ctrl_oe;
  assign bus_out   = bus_out_q;
  assign intr_in   = intr_in_q;
  assign vec_valid = vec_valid_q;
  assign vec_id    = vec_id_q;
  assign busy      = busy_q;
  assign vec_err   = vec_err_q;
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
  assign tmo_err   = tmo_err_q;
`endif

endmodule

// File: tb/tb_pes_ic_cpu_if.sv
// Self-checking bench for pes_ic_cpu_if: vector table, hand sequences and randomized
// transactions checked cycle by cycle against a timeline model.
module tb_pes_ic_cpu_if;

  localparam int ACK_DLY = 6;
  localparam int GAP     = 10;
  localparam int TMO_CYC = 32;
  localparam int A       = ACK_DLY;

  logic        clk_in = 1'b0;
  logic        rst_in, intr_out, ctrl_oe, cfg_start, cfg_prio, eoi_req;
  logic [7:0]  bus_in, bus_out;
  logic [23:0] prio_order;
  logic        bus_drive, intr_in, vec_valid, busy, vec_err;
  logic [2:0]  vec_id;
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
  logic        tmo_err;
`endif

  int total = 0;
  int bad   = 0;

  // Architectural state the model tracks between transactions.
  logic       m_mode = 1'b0;
  logic [2:0] m_id   = 3'd0;
  logic       m_err  = 1'b0;

  always #5 clk_in = ~clk_in;

  pes_ic_cpu_if #(.ACK_DLY(ACK_DLY), .GAP(GAP), .TMO_CYC(TMO_CYC)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .intr_out   (intr_out),
    .ctrl_oe    (ctrl_oe),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_drive  (bus_drive),
    .intr_in    (intr_in),
    .cfg_start  (cfg_start),
    .cfg_prio   (cfg_prio),
    .prio_order (prio_order),
    .vec_valid  (vec_valid),
    .vec_id     (vec_id),
    .eoi_req    (eoi_req),
    .busy       (busy),
    .vec_err    (vec_err)
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
    ,
    .tmo_err    (tmo_err)
`endif
  );

  typedef struct packed {
    logic       ii;
    logic       dr;
    logic [7:0] bus;
    logic       vv;
    logic [2:0] id;
    logic       bz;
    logic       er;
  } obs_t;

  typedef struct {
    logic       prio;
    logic [7:0] vec;
    int         d;
    int         e;
    logic       exp_err;
    logic [2:0] exp_id;
    logic       exp_vv;
    logic [7:0] exp_eoi;
  } vec_rec_t;

  function automatic obs_t mk(logic ii, logic dr, logic [7:0] b, logic vv, logic [2:0] id,
                              logic bz, logic er);
    obs_t o;
    o = {ii, dr, b, vv, id, bz, er};
    return o;
  endfunction

  function automatic obs_t idle_obs();
    return mk(1'b1, 1'b0, 8'h00, 1'b0, m_id, 1'b0, m_err);
  endfunction

  // Programming word k: ranks 2k and 2k+1 packed as id_hi*32 + id_lo*4 + tag.
  function automatic logic [7:0] model_word(logic prio, logic [23:0] order, int k);
    int hi, lo;
    if (!prio) return 8'h01;
    hi = int'((order >> (6 * k)) & 24'd7);
    lo = int'((order >> (6 * k + 3)) & 24'd7);
    return 8'(hi * 32 + lo * 4 + 2);
  endfunction

  task automatic check_obs(input string nm, input obs_t exp);
    obs_t act;
    act = {intr_in, bus_drive, bus_out, vec_valid, vec_id, busy, vec_err};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got ii=%b dr=%b bus=%h vv=%b id=%0d busy=%b err=%b, want ii=%b dr=%b bus=%h vv=%b id=%0d busy=%b err=%b",
               nm, $time, act.ii, act.dr, act.bus, act.vv, act.id, act.bz, act.er,
               exp.ii, exp.dr, exp.bus, exp.vv, exp.id, exp.bz, exp.er);
    end
  endtask

  task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic clr_in();
    intr_out  = 1'b0;
    ctrl_oe   = 1'b0;
    cfg_start = 1'b0;
    eoi_req   = 1'b0;
    bus_in    = 8'h00;
  endtask

  task automatic adv();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_cfg(input logic prio, input logic [23:0] order, input int oe_at);
    int w;
    w = prio ? 4 : 1;
    clr_in();
    prio_order = order;
    cfg_start  = 1'b1;
    cfg_prio   = prio;
    @(negedge clk_in);
    check_obs("cfg_req", idle_obs());
    adv();
    m_mode = prio;
    m_err  = 1'b0;
    for (int c = 1; c <= w + 1; c++) begin
      clr_in();
      ctrl_oe = (c - 1 == oe_at);
      if (c == 1) begin
        cfg_start = 1'b1;
        cfg_prio  = ~prio;
      end
      @(negedge clk_in);
      if (c <= w) check_obs("cfg_word", mk(1'b1, ~ctrl_oe, model_word(prio, order, c - 1), 1'b0, m_id, 1'b1, 1'b0));
      else        check_obs("cfg_end", idle_obs());
      adv();
    end
  endtask

  task automatic run_irq(input logic [7:0] vec, input int d, input int e, input bit oe_eoi,
                         input bit noise, output bit saw_vv, output logic [7:0] eoi_word);
    int   k, m, svc_end, last;
    logic good, ev_ii, ev_vv, ev_bz, ev_dr;
    logic [7:0] ev_bus;
    good    = (vec[7:3] == (m_mode ? 5'b10011 : 5'b01011));
    k       = A + 2 + d;
    svc_end = k + 2 + e;
    m       = good ? svc_end + 1 : k + 2;
    last    = m + GAP + 1;
    saw_vv  = 1'b0;
    eoi_word = 8'hxx;
    for (int c = 0; c <= last; c++) begin
      clr_in();
      intr_out = (c <= A);
      if (c == k) begin
        ctrl_oe = 1'b1;
        bus_in  = vec;
      end
      if (c == m && oe_eoi) ctrl_oe = 1'b1;
      if (noise) begin
        if (c > A && c <= m + GAP) intr_out = 1'($urandom);
        if (c >= 1 && c <= m + GAP) begin
          cfg_start = ($urandom_range(0, 3) == 0);
          cfg_prio  = 1'($urandom);
        end
        if (!(good && c >= k + 2 && c <= svc_end)) eoi_req = ($urandom_range(0, 3) == 0);
      end
      if (good && c == svc_end) eoi_req = 1'b1;
      if (c == k + 1) begin
        m_id = vec[2:0];
        if (!good) m_err = 1'b1;
      end
      ev_ii  = !(c == A + 1 || c == k + 1 || c == m);
      ev_dr  = (c == m) && !oe_eoi;
      ev_bus = (c == m) ? 8'((m_mode ? 12 : 20) * 8 + int'(m_id)) : 8'h00;
      ev_vv  = good && c >= k + 2 && c <= svc_end;
      ev_bz  = (c >= 1 && c <= m + GAP);
      @(negedge clk_in);
      check_obs("irq_cyc", mk(ev_ii, ev_dr, ev_bus, ev_vv, m_id, ev_bz, m_err));
      if (c == m) eoi_word = bus_out;
      if (vec_valid === 1'b1) saw_vv = 1'b1;
      adv();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t   tbl [5];
    logic [7:0] exp_w [4];
    logic [23:0] ord;
    logic [7:0] eoiw, vec;
    logic [4:0] pfx;
    bit         saw;
    logic       p;

    tbl[0] = '{prio: 1'b0, vec: 8'b01011_011, d: 0, e: 0, exp_err: 1'b0, exp_id: 3'd3, exp_vv: 1'b1, exp_eoi: 8'b10100_011};
    tbl[1] = '{prio: 1'b1, vec: 8'b01011_101, d: 2, e: 0, exp_err: 1'b1, exp_id: 3'd5, exp_vv: 1'b0, exp_eoi: 8'b01100_101};
    tbl[2] = '{prio: 1'b1, vec: 8'b10011_110, d: 1, e: 3, exp_err: 1'b0, exp_id: 3'd6, exp_vv: 1'b1, exp_eoi: 8'b01100_110};
    tbl[3] = '{prio: 1'b0, vec: 8'b10011_000, d: 3, e: 1, exp_err: 1'b1, exp_id: 3'd0, exp_vv: 1'b0, exp_eoi: 8'b10100_000};
    tbl[4] = '{prio: 1'b0, vec: 8'b01011_111, d: 0, e: 2, exp_err: 1'b0, exp_id: 3'd7, exp_vv: 1'b1, exp_eoi: 8'b10100_111};
    exp_w[0] = 8'b101_011_10;
    exp_w[1] = 8'b111_000_10;
    exp_w[2] = 8'b100_010_10;
    exp_w[3] = 8'b110_001_10;

    clr_in();
    cfg_prio   = 1'b0;
    prio_order = '0;
    rst_in     = 1'b1;
    adv();
    adv();
    rst_in = 1'b0;
    @(negedge clk_in);
    check_obs("reset", mk(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
`ifdef PES_IC_CPU_IF_TIMEOUT_EN
    check_val("reset_tmo", {7'd0, tmo_err}, 8'd0);
`endif
    adv();

    // Polling programming: one word 01, then bus released.
    cfg_start = 1'b1;
    cfg_prio  = 1'b0;
    adv();
    clr_in();
    @(negedge clk_in);
    check_val("poll_word", bus_out, 8'h01);
    check_val("poll_drive", {6'd0, bus_drive, intr_in}, 8'b11);
    adv();
    @(negedge clk_in);
    check_val("poll_release", {6'd0, bus_drive, busy}, 8'b00);
    adv();

    // Priority programming with ranks 5,3,7,0,4,2,6,1.
    cfg_start  = 1'b1;
    cfg_prio   = 1'b1;
    prio_order = {3'd1, 3'd6, 3'd2, 3'd4, 3'd0, 3'd7, 3'd3, 3'd5};
    adv();
    clr_in();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check_val("prio_word", bus_out, exp_w[i]);
      check_val("prio_drive", {7'd0, bus_drive}, 8'd1);
      adv();
    end
    @(negedge clk_in);
    check_val("prio_release", {6'd0, bus_drive, busy}, 8'b00);
    adv();
    m_mode = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_cfg(tbl[i].prio, 24'($urandom), -1);
      run_irq(tbl[i].vec, tbl[i].d, tbl[i].e, 1'b0, 1'b0, saw, eoiw);
      check_val("tbl_err", {7'd0, vec_err}, {7'd0, tbl[i].exp_err});
      check_val("tbl_id", {5'd0, vec_id}, {5'd0, tbl[i].exp_id});
      check_val("tbl_vv", {7'd0, saw}, {7'd0, tbl[i].exp_vv});
      check_val("tbl_eoi", eoiw, tbl[i].exp_eoi);
    end

    // Short intr_out pulse is dropped before the ack delay expires.
    for (int c = 0; c <= 8; c++) begin
      clr_in();
      intr_out = (c <= 2);
      @(negedge clk_in);
      check_obs("spurious", mk(1'b1, 1'b0, 8'h00, 1'b0, m_id, (c >= 1 && c <= 3), m_err));
      adv();
    end

    // cfg_start wins over a simultaneous intr_out.
    clr_in();
    cfg_start = 1'b1;
    cfg_prio  = 1'b0;
    intr_out  = 1'b1;
    adv();
    clr_in();
    m_mode = 1'b0;
    m_err  = 1'b0;
    @(negedge clk_in);
    check_obs("cfg_first", mk(1'b1, 1'b1, 8'h01, 1'b0, m_id, 1'b1, 1'b0));
    adv();
    @(negedge clk_in);
    check_obs("cfg_first_end", idle_obs());
    adv();

    // Reset during SERVICE returns everything, including the mode, to reset values.
    do_cfg(1'b1, 24'($urandom), -1);
    for (int c = 0; c <= A + 4; c++) begin
      clr_in();
      intr_out = (c <= A);
      if (c == A + 2) begin
        ctrl_oe = 1'b1;
        bus_in  = 8'b10011_010;
      end
      if (c == A + 4) rst_in = 1'b1;
      @(negedge clk_in);
      if (c == A + 4) check_val("svc_before_rst", {7'd0, vec_valid}, 8'd1);
      adv();
    end
    rst_in = 1'b0;
    clr_in();
    m_mode = 1'b0;
    m_id   = 3'd0;
    m_err  = 1'b0;
    @(negedge clk_in);
    check_obs("rst_in_svc", mk(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    adv();
    run_irq(8'b01011_100, 0, 0, 1'b0, 1'b0, saw, eoiw);
    check_val("post_rst_mode", eoiw, 8'b10100_100);

    // Randomized programming and transactions with bus contention and input noise.
    for (int it = 0; it < 6; it++) begin
      p   = 1'($urandom);
      ord = 24'($urandom);
      do_cfg(p, ord, int'($urandom_range(0, 4)) - 1);
      for (int t = 0; t < 3; t++) begin
        pfx = ($urandom_range(0, 1) == 1) ? (m_mode ? 5'b10011 : 5'b01011) : 5'($urandom);
        vec = {pfx, 3'($urandom)};
        run_irq(vec, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                1'($urandom), 1'b1, saw, eoiw);
      end
    end

`ifdef PES_IC_CPU_IF_TIMEOUT_EN
    // Controller never drives the vector: capture gives up after TMO_CYC cycles.
    for (int c = 0; c <= A + 4 + TMO_CYC; c++) begin
      clr_in();
      intr_out = (c <= A);
      @(negedge clk_in);
      check_obs("tmo_cyc", mk(!(c == A + 1), 1'b0, 8'h00, 1'b0, m_id,
                              (c >= 1 && c <= A + 1 + TMO_CYC), m_err));
      check_val("tmo_err", {7'd0, tmo_err}, {7'd0, (c >= A + 2 + TMO_CYC)});
      adv();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
